sram_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port 8-bit SRAM between `NUM_REQ` requesters. Each requester issues read/write commands over a valid/ready handshake. The arbiter forwards one command per cycle to the SRAM port (`en`, `wr`, `addr`, `wr_data` / `rd_data`). It also routes read data back to the issuing requester. It sits between the testbench-side agents and the SRAM DUT.

---
 rtl/sram_arb_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/sram_arbiter.sv | 103 ++++++++++
 tb/tb_sram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and sizing helpers for the SRAM round-robin arbiter.
//   - DEF_* : default sizes of the arbiter parameters
//   - ID_W / id_width(): requester-index width, never below one bit
//   - sram_cmd_t : one SRAM command {wr, addr, wdata} at default widths
//   - rd_tag_t   : read-tracker entry {vld, id}; id is wide enough for 8 requesters
package sram_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 8;
  localparam int MAX_NUM_REQ = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W     = (DEF_NUM_REQ > 1) ? $clog2(DEF_NUM_REQ) : 1;
  localparam int TAG_ID_W = (MAX_NUM_REQ > 1) ? $clog2(MAX_NUM_REQ) : 1;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } sram_cmd_t;

  // Sized for the largest supported requester count so one tag type serves
  // every NUM_REQ in 2..8.
  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered rotating pointer.
//   clk, rst  : clock, asynchronous active-high reset (pointer -> 0)
//   valid     : per-requester request
//   grant     : one-hot grant to the first valid requester at or after ptr
//   grant_vld : any grant this cycle
//   grant_id  : binary index of the granted requester
// After a grant to i the pointer moves to (i+1) mod NUM_REQ; it holds when idle.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_vld,
  output logic [IDW-1:0]     grant_id
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers latches.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = IDW'((int'(ptr) + off) % NUM_REQ);
      if (!grant_vld && valid[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between NUM_REQ requesters.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/wr/addr/wdata: per-requester command (packed slices, requester i at slice i)
//   req_ready             : one-hot accept, high only in the transfer cycle
//   rsp_valid, rsp_rdata  : one-hot read return and shared read data
//   sram_en/wr/addr/wdata : registered SRAM command, one command per cycle
//   sram_rdata            : SRAM read data, valid RD_LAT cycles after the command
// A grant in cycle T shows on the SRAM port in T+1; read data returns to the
// issuing requester in T+1+RD_LAT, in issue order.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      sram_en,
  output logic                      sram_wr,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  input  logic [DATA_W-1:0]         sram_rdata
);

  localparam int IDW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic               grant_vld;
  logic [IDW-1:0]     gid;

  // Id and read flag of the command currently on the SRAM port.
  logic               cmd_rd;
  logic [IDW-1:0]     cmd_id;

  rd_tag_t            tags [RD_LAT];
  rd_tag_t            tap;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_id  (gid)
  );

  // Grant is purely combinational from valid and ptr; masked so no accept is
  // signalled while reset is held.
  assign req_ready = rst ? '0 : grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_en    <= 1'b0;
      sram_wr    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      cmd_rd     <= 1'b0;
      cmd_id     <= '0;
    end else begin
      sram_en <= grant_vld;
      sram_wr <= grant_vld & req_wr[gid];
      cmd_rd  <= grant_vld & ~req_wr[gid];
      cmd_id  <= gid;
      if (grant_vld) begin
        sram_addr  <= req_addr[gid*ADDR_W +: ADDR_W];
        sram_wdata <= req_wdata[gid*DATA_W +: DATA_W];
      end
    end
  end

  // The tracker is fed from the command stage, so its last entry lines up with
  // sram_rdata RD_LAT cycles after the command cycle.
  // NOTE: this small shift register is reset because stale valid bits would
  // produce phantom responses; plain data storage would not need a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) tags[k] <= '0;
    end else begin
      tags[0] <= '{vld: cmd_rd, id: TAG_ID_W'(cmd_id)};
      for (int k = 1; k < RD_LAT; k++) tags[k] <= tags[k-1];
    end
  end

  assign tap       = tags[RD_LAT-1];
  assign rsp_rdata = sram_rdata;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = !rst && tap.vld && (tap.id == TAG_ID_W'(i));
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter. Two instances (RD_LAT 1
// and 3) see identical stimulus, each with its own behavioural SRAM. Expected
// grants come from a round-robin model; expected SRAM commands and read
// responses are queued at grant time and compared when due.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_wr    = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;

  logic [1:0][N-1:0]  ready;
  logic [1:0][N-1:0]  rspv;
  logic [1:0][DW-1:0] rdata;
  logic [1:0]         en;
  logic [1:0]         wr;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;
  logic [1:0][DW-1:0] sram_rdata;

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [LAT];

    always @(posedge clk) begin
      if (en[g] && wr[g]) mem[addr[g][7:0]] <= wdata[g];
      pipe[0] <= mem[addr[g][7:0]];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign sram_rdata[g] = pipe[LAT-1];

    sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (ready[g]),
      .rsp_valid  (rspv[g]),
      .rsp_rdata  (rdata[g]),
      .sram_en    (en[g]),
      .sram_wr    (wr[g]),
      .sram_addr  (addr[g]),
      .sram_wdata (wdata[g]),
      .sram_rdata (sram_rdata[g])
    );
  end

  typedef struct {int cyc; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;} exp_cmd_t;
  typedef struct {int cyc; int id; logic [DW-1:0] data;} exp_rsp_t;

  exp_cmd_t  cmd_q [$];
  exp_rsp_t  rsp_q [2][$];
  sram_cmd_t req_q [N][$];
  logic [DW-1:0] ref_mem [256];
  int grant_log [$];
  int mptr  = 0;
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_cmd(input int id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_q[id].push_back('{wr: w, addr: a, wdata: d});
  endtask

  function automatic int pending();
    int p;
    p = cmd_q.size() + rsp_q[0].size() + rsp_q[1].size();
    for (int i = 0; i < N; i++) p += req_q[i].size();
    return p;
  endfunction

  // One clock cycle: drive queue heads, then check registered outputs,
  // responses and the grant against the model.
  task automatic step();
    exp_cmd_t  e;
    exp_rsp_t  r;
    sram_cmd_t c;
    int gnt;
    int idx;
    logic [N-1:0] expv;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (req_q[i].size() > 0);
      if (req_q[i].size() > 0) begin
        req_wr[i]               = req_q[i][0].wr;
        req_addr[i*AW +: AW]    = req_q[i][0].addr;
        req_wdata[i*DW +: DW]   = req_q[i][0].wdata;
      end
    end
    @(negedge clk);
    if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
      e = cmd_q.pop_front();
      for (int g = 0; g < 2; g++) begin
        check("sram_en",    64'(en[g]),    64'(1'b1));
        check("sram_wr",    64'(wr[g]),    64'(e.wr));
        check("sram_addr",  64'(addr[g]),  64'(e.addr));
        check("sram_wdata", 64'(wdata[g]), 64'(e.wdata));
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        check("sram_en_idle", 64'(en[g]), 64'(1'b0));
        check("sram_wr_idle", 64'(wr[g]), 64'(1'b0));
      end
    end
    for (int g = 0; g < 2; g++) begin
      if (rsp_q[g].size() > 0 && rsp_q[g][0].cyc == cyc) begin
        r = rsp_q[g].pop_front();
        check("rsp_valid", 64'(rspv[g]),  64'(N'(1) << r.id));
        check("rsp_rdata", 64'(rdata[g]), 64'(r.data));
      end else begin
        check("rsp_valid_idle", 64'(rspv[g]), 64'(0));
      end
    end
    gnt = -1;
    for (int off = 0; off < N; off++) begin
      idx = (mptr + off) % N;
      if (gnt < 0 && req_valid[idx]) gnt = idx;
    end
    expv = (gnt >= 0) ? (N'(1) << gnt) : '0;
    for (int g = 0; g < 2; g++) check("req_ready", 64'(ready[g]), 64'(expv));
    if (gnt >= 0) begin
      c = req_q[gnt].pop_front();
      grant_log.push_back(gnt);
      cmd_q.push_back('{cyc + 1, c.wr, c.addr, c.wdata});
      if (c.wr) ref_mem[c.addr[7:0]] = c.wdata;
      else for (int g = 0; g < 2; g++) rsp_q[g].push_back('{cyc + 1 + lat(g), gnt, ref_mem[c.addr[7:0]]});
      mptr = (gnt + 1) % N;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_left", 64'(pending()), 64'(0));
  endtask

  // Asserts reset in the cycle after the call and checks all outputs are 0.
  task automatic apply_reset(input int ncyc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cmd_q.delete();
    for (int g = 0; g < 2; g++) rsp_q[g].delete();
    for (int i = 0; i < N; i++) req_q[i].delete();
    req_valid = '0;
    mptr = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        check("rst_ready",      64'(ready[g]), 64'(0));
        check("rst_rsp_valid",  64'(rspv[g]),  64'(0));
        check("rst_sram_en",    64'(en[g]),    64'(0));
        check("rst_sram_wr",    64'(wr[g]),    64'(0));
        check("rst_sram_addr",  64'(addr[g]),  64'(0));
        check("rst_sram_wdata", 64'(wdata[g]), 64'(0));
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic check_log(input string tag, input int exp0, input int exp1, input int exp2, input int cnt);
    int exp_seq [3];
    exp_seq = '{exp0, exp1, exp2};
    check({tag, "_len"}, 64'(grant_log.size()), 64'(cnt));
    for (int k = 0; k < cnt && k < grant_log.size(); k++)
      check(tag, 64'(grant_log[k]), 64'(exp_seq[k]));
  endtask

  initial begin
    int per_req [N];
    for (int a = 0; a < 256; a++) ref_mem[a] = '0;

    // Reset state
    apply_reset(3);

    // Single write then read by requester 2
    push_cmd(2, 1'b1, 32'h10, 8'hA5);
    drain(20);
    push_cmd(2, 1'b0, 32'h10, 8'h00);
    drain(20);
    idle(2);

    // All four valid continuously from ptr=0
    apply_reset(1);
    grant_log.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push_cmd(i, 1'b1, 32'(8'h20 + i*2 + k), 8'(8'h40 + i*16 + k));
    drain(40);
    check("rr8_len", 64'(grant_log.size()), 64'(8));
    for (int i = 0; i < N; i++) per_req[i] = 0;
    for (int k = 0; k < grant_log.size(); k++) begin
      check("rr8_seq", 64'(grant_log[k]), 64'(k % N));
      if (grant_log[k] >= 0 && grant_log[k] < N) per_req[grant_log[k]]++;
    end
    for (int i = 0; i < N; i++) check("rr8_count", 64'(per_req[i]), 64'(2));

    // Fairness after an idle gap: grant 1 leaves ptr=2, then 3 before 0
    grant_log.delete();
    push_cmd(1, 1'b1, 32'h30, 8'h5A);
    drain(20);
    idle(3);
    push_cmd(0, 1'b1, 32'h31, 8'h01);
    push_cmd(3, 1'b1, 32'h32, 8'h03);
    drain(20);
    check_log("fair", 1, 3, 0, 3);

    // Interleaved reads 0,1,0 of addrs 1,2,3
    push_cmd(2, 1'b1, 32'h1, 8'h11);
    push_cmd(2, 1'b1, 32'h2, 8'h22);
    push_cmd(2, 1'b1, 32'h3, 8'h33);
    drain(20);
    grant_log.delete();
    push_cmd(0, 1'b0, 32'h1, 8'h00);
    push_cmd(0, 1'b0, 32'h3, 8'h00);
    push_cmd(1, 1'b0, 32'h2, 8'h00);
    drain(20);
    check_log("ilv", 0, 1, 0, 3);

    // Single requester streaming reads, granted every cycle
    grant_log.delete();
    for (int k = 0; k < 4; k++) push_cmd(1, 1'b0, 32'(k + 1), 8'h00);
    drain(20);
    check("stream_len", 64'(grant_log.size()), 64'(4));
    for (int k = 0; k < grant_log.size(); k++) check("stream_id", 64'(grant_log[k]), 64'(1));

    // Reset one cycle after a read is accepted
    grant_log.delete();
    push_cmd(0, 1'b0, 32'h2, 8'h00);
    step();
    check("pre_rst_grant", 64'(grant_log.size()), 64'(1));
    apply_reset(2);
    idle(6);
    grant_log.delete();
    push_cmd(3, 1'b0, 32'h3, 8'h00);
    push_cmd(1, 1'b1, 32'h44, 8'hC3);
    drain(20);
    check_log("post_rst", 1, 3, 0, 2);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
